// File: rtl/pipelined_csel_adder.sv
// rtl/pipelined_csel_adder.sv - two-stage pipelined carry-select adder with valid/ready flow control
// Define CSEL_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSEL_OVF_EN
 ,output logic             ovf
`endif
);

  localparam int  BLK_SAFE = (BLK >= 1) ? BLK : 1;
  localparam bit  CFG_OK   = (BLK >= 1) && (WIDTH >= BLK) && ((WIDTH % BLK_SAFE) == 0);
  localparam int  NB       = (WIDTH / BLK_SAFE >= 1) ? WIDTH / BLK_SAFE : 1;

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("pipelined_csel_adder: WIDTH must be a multiple of BLK with WIDTH >= BLK >= 1");
    end
  endgenerate

  logic                     en;
  logic [NB-1:0][BLK_SAFE-1:0] s0_d, s1_d, s0_q, s1_q;
  logic [NB-1:0]            c0_d, c1_d, c0_q, c1_q;
  logic                     cin_q, v1_q;
  logic [WIDTH-1:0]         sum_d, sum_q;
  logic                     cout_d, cout_q, out_valid_q;

  // A stalled output freezes the whole pipe; otherwise every stage advances.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    s0_d = '0;
    s1_d = '0;
    c0_d = '0;
    c1_d = '0;
    for (int k = 0; k < NB; k++) begin
      {c0_d[k], s0_d[k]} = {1'b0, a[k*BLK_SAFE +: BLK_SAFE]} + {1'b0, b[k*BLK_SAFE +: BLK_SAFE]};
      {c1_d[k], s1_d[k]} = {1'b0, a[k*BLK_SAFE +: BLK_SAFE]} + {1'b0, b[k*BLK_SAFE +: BLK_SAFE]}
                           + {{BLK_SAFE{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else if (en) begin
      v1_q  <= in_valid;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      c0_q  <= c0_d;
      c1_q  <= c1_d;
      cin_q <= cin;
    end
  end

  always_comb begin
    logic carry;
    carry = cin_q;
    sum_d = '0;
    for (int k = 0; k < NB; k++) begin
      sum_d[k*BLK_SAFE +: BLK_SAFE] = carry ? s1_q[k] : s0_q[k];
      carry                         = carry ? c1_q[k] : c0_q[k];
    end
    cout_d = carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (en) begin
      out_valid_q <= v1_q;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

`ifdef CSEL_OVF_EN
  logic a_msb_q, b_msb_q, ovf_d, ovf_q;

  assign ovf_d = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
  assign ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (en) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb/tb_pipelined_csel_adder.sv - scoreboard bench for pipelined_csel_adder at 16/4, 8/2 and 32/8
// Honours CSEL_OVF_EN by connecting and checking ovf.
module tb_pipelined_csel_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a32, b32;
  logic        cin;

  logic        ir16, ov16, co16, of16;
  logic [15:0] s16;
  logic        ir8, ov8, co8, of8;
  logic [7:0]  s8;
  logic        ir32, ov32, co32, of32;
  logic [31:0] s32;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 0;

  logic [33:0] q16[$];
  logic [33:0] q8[$];
  logic [33:0] q32[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .BLK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
    .a(a32[15:0]), .b(b32[15:0]), .cin(cin),
    .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16)
`ifdef CSEL_OVF_EN
   ,.ovf(of16)
`endif
  );

  pipelined_csel_adder #(.WIDTH(8), .BLK(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
    .a(a32[7:0]), .b(b32[7:0]), .cin(cin),
    .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8)
`ifdef CSEL_OVF_EN
   ,.ovf(of8)
`endif
  );

  pipelined_csel_adder #(.WIDTH(32), .BLK(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin),
    .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32)
`ifdef CSEL_OVF_EN
   ,.ovf(of32)
`endif
  );

`ifndef CSEL_OVF_EN
  assign of16 = 1'b0;
  assign of8  = 1'b0;
  assign of32 = 1'b0;
`endif

  // Reference: plain integer addition in w+1 bits, ovf from the two's-complement sign rule.
  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic c, input int w);
    longint unsigned m, s;
    logic [33:0] r;
    m = (64'd1 << w) - 64'd1;
    s = (longint'(av) & m) + (longint'(bv) & m) + longint'(c);
    r = '0;
    r[31:0] = 32'(s & m);
    r[32]   = s[w];
    r[33]   = (av[w-1] == bv[w-1]) && (r[w-1] != av[w-1]);
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [33:0] got, input logic [33:0] exp);
    logic [33:0] msk;
`ifdef CSEL_OVF_EN
    msk = 34'h3_FFFF_FFFF;
`else
    msk = 34'h1_FFFF_FFFF;
`endif
    checks++;
    if ((got & msk) !== (exp & msk)) begin
      errors++;
      $display("FAIL %s got ovf/cout/sum=%h expected=%h at %0t", nm, got & msk, exp & msk, $time);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: pops and compares whenever a result is handed over.
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", {31'd0, ov16}, 32'd1);
        cmp("stall_data_hold", {of16, co16, 16'd0, s16}, prev_out);
      end
      if (ov16 && !out_ready) chk("stall_in_ready", {31'd0, ir16}, 32'd0);
      prev_stall = ov16 && !out_ready;
      prev_out   = {of16, co16, 16'd0, s16};

      if (ov16 && out_ready) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL u16_unexpected_result got sum=%h expected=none", s16);
        end else cmp("u16_result", {of16, co16, 16'd0, s16}, q16.pop_front());
      end
      if (ov8 && out_ready) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL u8_unexpected_result got sum=%h expected=none", s8);
        end else cmp("u8_result", {of8, co8, 24'd0, s8}, q8.pop_front());
      end
      if (ov32 && out_ready) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL u32_unexpected_result got sum=%h expected=none", s32);
        end else cmp("u32_result", {of32, co32, s32}, q32.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic c,
                       input bit use_k, input logic [33:0] k16);
    bit acc;
    int n;
    a32 = av; b32 = bv; cin = c; in_valid = 1'b1;
    acc = 0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      n++;
      if (ir16 && !rst) begin
        acc = 1;
        q16.push_back(use_k ? k16 : model(av, bv, c, 16));
        if (ir8)  q8.push_back(model(av, bv, c, 8));
        if (ir32) q32.push_back(model(av, bv, c, 32));
      end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout got in_ready=%b expected=1 within 200 cycles", ir16);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() + q8.size() + q32.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q16.size() + q8.size() + q32.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt, run, maxrun;
    logic [15:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a32 = '0; b32 = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {29'd0, ov16, ov8, ov32}, 32'd0);
    chk("reset_sum16", {16'd0, s16}, 32'd0);
    chk("reset_cout_ovf", {28'd0, co16, co8, co32, of16}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {31'd0, ir16}, 32'd1);
    @(posedge clk); #1;

    issue(32'h0009, 32'h000A, 1'b0, 1, {2'b00, 32'h0013});
    issue(32'hFFFF, 32'h0000, 1'b1, 1, {2'b01, 32'h0000});
    issue(32'h7FFF, 32'h0001, 1'b0, 1, {2'b10, 32'h8000});
    drain();

    cnt = 0; run = 0; maxrun = 0;
    fork
      begin
        issue(32'h000D, 32'h0006, 1'b1, 1, {2'b00, 32'h0014});
        issue(32'h0005, 32'h0007, 1'b1, 1, {2'b00, 32'h000D});
        issue(32'h000C, 32'h000B, 1'b0, 1, {2'b00, 32'h0017});
        issue(32'h000E, 32'h0003, 1'b1, 1, {2'b00, 32'h0012});
        issue(32'hABCD, 32'h1234, 1'b0, 1, {2'b00, 32'hBE01});
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (ov16) begin cnt++; run++; end else run = 0;
          if (run > maxrun) maxrun = run;
        end
      end
    join
    chk("stream_valid_count", cnt, 32'd5);
    chk("stream_back_to_back", maxrun, 32'd5);
    drain();

    out_ready = 1'b0;
    fork
      begin
        issue(32'h1111, 32'h2222, 1'b0, 0, '0);
        issue(32'h8000, 32'h8000, 1'b1, 0, '0);
        issue(32'hFFF0, 32'h0010, 1'b0, 0, '0);
        issue(32'h4000, 32'h4000, 1'b0, 0, '0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!ov16 && n < 20) begin @(negedge clk); n++; end
        chk("stall_result_pending", {31'd0, ov16}, 32'd1);
        held = s16;
        repeat (4) begin
          @(negedge clk);
          chk("stall4_in_ready", {31'd0, ir16}, 32'd0);
          chk("stall4_sum", {16'd0, s16}, {16'd0, held});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    issue(32'h0101, 32'h0202, 1'b0, 0, '0);
    issue(32'h0303, 32'h0404, 1'b1, 0, '0);
    rst = 1'b1;
    @(negedge clk);
    q16.delete(); q8.delete(); q32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", {29'd0, ov16, ov8, ov32}, 32'd0);
    chk("post_reset_in_ready", {31'd0, ir16}, 32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;

    rand_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 0, '0);
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
